// File: rtl/pipe_frame_pkg.sv
// Shared definitions for the pipeline frame skid buffer: state encoding and field slicing.
// FIELD_WIDTH defaults to `DATA_WIDTH from the global header, falling back to 32 when no header sets it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pipe_frame_pkg;

  localparam int PF_DEFAULT_FIELD_W = `DATA_WIDTH;

  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_FULL  = 2'd1,
    PF_SKID  = 2'd2
  } pf_state_t;

  // Low bit of field k in a frame built from w-bit fields.
  function automatic int field(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_frame_patch_merge.sv
// Combinational per-field merge: for each field k, take the patch value when i_we[k] is set, else keep the head.
// Zero latency. It has no handshake, so backpressure does not apply.
module pipe_frame_patch_merge
  import pipe_frame_pkg::*;
#(
  parameter int FIELD_WIDTH = PF_DEFAULT_FIELD_W,
  parameter int NUM_FIELDS  = 8
) (
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] i_head,
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] i_patch,
  input  logic [NUM_FIELDS-1:0]             i_we,
  output logic [NUM_FIELDS*FIELD_WIDTH-1:0] o_dat
);

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    assign o_dat[field(k, FIELD_WIDTH) +: FIELD_WIDTH] =
      i_we[k] ? i_patch[field(k, FIELD_WIDTH) +: FIELD_WIDTH]
              : i_head[field(k, FIELD_WIDTH) +: FIELD_WIDTH];
  end

endmodule

// File: rtl/pipe_frame_skid.sv
// Two-entry skid buffer with a registered in_ready. Latency is 1 cycle, and the head can be flushed and patched.
// Backpressure: in_ready drops when both entries are held. Define PIPE_FRAME_STALL_CNT_EN to add the stall_count output.
module pipe_frame_skid
  import pipe_frame_pkg::*;
#(
  parameter int FIELD_WIDTH     = PF_DEFAULT_FIELD_W,
  parameter int NUM_FIELDS      = 8,
  parameter int STALL_CNT_WIDTH = 16,
  localparam int FRAME_W        = NUM_FIELDS * FIELD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAME_W-1:0]    in_data,
  input  logic [NUM_FIELDS-1:0] patch_we,
  input  logic [FRAME_W-1:0]    patch_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAME_W-1:0]    out_data
`ifdef PIPE_FRAME_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
`endif
);

  pf_state_t          r_state;
  logic [FRAME_W-1:0] r_head;
  logic [FRAME_W-1:0] r_skid;
  logic               r_in_ready;

  pf_state_t          w_next_state;
  logic [FRAME_W-1:0] w_next_head;
  logic [FRAME_W-1:0] w_next_skid;
  logic [FRAME_W-1:0] w_patched;
  logic               w_push;
  logic               w_pop;
  logic               w_out_valid;

  assign w_out_valid = (r_state != PF_EMPTY);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_head;

  pipe_frame_patch_merge #(
    .FIELD_WIDTH(FIELD_WIDTH),
    .NUM_FIELDS (NUM_FIELDS)
  ) u_merge (
    .i_head (r_head),
    .i_patch(patch_data),
    .i_we   (patch_we),
    .o_dat  (w_patched)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_skid  = r_skid;
    // A held head that is not leaving this cycle picks up any requested patches.
    w_next_head  = (w_out_valid && !w_pop) ? w_patched : r_head;
    if (flush) begin
      w_next_state = PF_EMPTY;
      w_next_head  = '0;
      w_next_skid  = '0;
    end else begin
      case (r_state)
        PF_EMPTY: begin
          if (w_push) begin
            w_next_state = PF_FULL;
            w_next_head  = in_data;
          end
        end
        PF_FULL: begin
          if (w_push && w_pop) begin
            w_next_head = in_data;
          end else if (w_push) begin
            w_next_state = PF_SKID;
            w_next_skid  = in_data;
          end else if (w_pop) begin
            w_next_state = PF_EMPTY;
          end
        end
        PF_SKID: begin
          if (w_pop) begin
            w_next_state = PF_FULL;
            w_next_head  = r_skid;
          end
        end
        default: w_next_state = PF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= PF_EMPTY;
      r_head     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_head     <= w_next_head;
      r_skid     <= w_next_skid;
      r_in_ready <= (w_next_state != PF_SKID);
    end
  end

`ifdef PIPE_FRAME_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && !flush &&
                 (r_stall_cnt != {STALL_CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_frame_skid.sv
// Directed bench for pipe_frame_skid. A queue model is checked on every negedge, and literal checks follow each step.
module tb_pipe_frame_skid;

  localparam int FW  = 16;
  localparam int NF  = 2;
  localparam int FRW = FW * NF;
  localparam int SCW = 4;

  logic           clk;
  logic           reset;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [FRW-1:0] in_data;
  logic [NF-1:0]  patch_we;
  logic [FRW-1:0] patch_data;
  logic           out_valid;
  logic           out_ready;
  logic [FRW-1:0] out_data;
`ifdef PIPE_FRAME_STALL_CNT_EN
  logic [SCW-1:0] stall_count;
`endif

  int tests = 0;
  int fails = 0;

  pipe_frame_skid #(
    .FIELD_WIDTH    (FW),
    .NUM_FIELDS     (NF),
    .STALL_CNT_WIDTH(SCW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .patch_we  (patch_we),
    .patch_data(patch_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_FRAME_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: the held frames as a FIFO of at most two entries.
  logic [FRW-1:0] q[$];
  logic           m_rdy;
  int             m_stall;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_rdy   = 1'b1;
      m_stall = 0;
    end else begin
      automatic bit push = in_valid && m_rdy;
      automatic bit pop  = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready && !flush && m_stall < (1 << SCW) - 1)
        m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && !pop)
          for (int k = 0; k < NF; k++)
            if (patch_we[k]) q[0][k*FW +: FW] = patch_data[k*FW +: FW];
        if (pop) void'(q.pop_front());
        if (push) q.push_back(in_data);
      end
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
      if (q.size() > 0) chk("model_out_data", out_data, q[0]);
`ifdef PIPE_FRAME_STALL_CNT_EN
      chk("model_stall_count", {28'b0, stall_count}, m_stall[31:0]);
`endif
    end
  end

  task automatic cyc(input logic iv, input logic [FRW-1:0] d, input logic ordy,
                     input logic fl, input logic [NF-1:0] pwe, input logic [FRW-1:0] pd);
    in_valid   = iv;
    in_data    = d;
    out_ready  = ordy;
    flush      = fl;
    patch_we   = pwe;
    patch_data = pd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 0; in_valid = 0; in_data = '0;
    patch_we = '0; patch_data = '0; out_ready = 0;
    #3;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_out_data", out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming at full rate
    cyc(1, 32'h1, 1, 0, 0, 0); chk("stream_1", out_data, 32'h1); chk("stream_rdy", {31'b0, in_ready}, 32'h1);
    cyc(1, 32'h2, 1, 0, 0, 0); chk("stream_2", out_data, 32'h2);
    cyc(1, 32'h3, 1, 0, 0, 0); chk("stream_3", out_data, 32'h3); chk("stream_rdy3", {31'b0, in_ready}, 32'h1);
    cyc(0, 0, 1, 0, 0, 0);     chk("stream_drain", {31'b0, out_valid}, 32'h0);

    // Backpressure fills the skid entry, and 0xC waits until there is room
    cyc(1, 32'hA, 0, 0, 0, 0); chk("bp_head_a", out_data, 32'hA);
    cyc(1, 32'hB, 0, 0, 0, 0); chk("bp_skid_rdy", {31'b0, in_ready}, 32'h0);
    cyc(1, 32'hC, 0, 0, 0, 0); chk("bp_hold_a", out_data, 32'hA);
    cyc(1, 32'hC, 1, 0, 0, 0); chk("bp_out_b", out_data, 32'hB); chk("bp_rdy_back", {31'b0, in_ready}, 32'h1);
    cyc(1, 32'hC, 1, 0, 0, 0); chk("bp_out_c", out_data, 32'hC);
    cyc(0, 0, 1, 0, 0, 0);     chk("bp_drain", {31'b0, out_valid}, 32'h0);

    // Patching changes the held head only, never the skid entry
    cyc(1, 32'h0020_0010, 0, 0, 0, 0);           chk("patch_head", out_data, 32'h0020_0010);
    cyc(1, 32'h0040_0030, 0, 0, 2'b10, 32'h0099_0000);
    chk("patch_applied", out_data, 32'h0099_0010);
    cyc(0, 0, 1, 0, 2'b01, 32'h0000_00EE);       chk("patch_skid_intact", out_data, 32'h0040_0030);
    cyc(0, 0, 1, 0, 0, 0);                       chk("patch_drain", {31'b0, out_valid}, 32'h0);

    // Flush during SKID while upstream is still offering a frame
    cyc(1, 32'h51, 0, 0, 0, 0);
    cyc(1, 32'h52, 0, 0, 0, 0);
    cyc(1, 32'h53, 0, 1, 2'b11, 32'hFFFF_FFFF);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_rdy", {31'b0, in_ready}, 32'h1);
    chk("flush_data", out_data, 32'h0);
    cyc(0, 0, 0, 0, 0, 0); chk("flush_stays_empty", {31'b0, out_valid}, 32'h0);

    // Flush in FULL swallows the frame pushed on the same edge
    cyc(1, 32'h61, 0, 0, 0, 0);
    cyc(1, 32'h62, 0, 1, 0, 0);
    cyc(1, 32'h63, 1, 0, 0, 0); chk("flush_push_dropped", out_data, 32'h63);
    cyc(0, 0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle while in SKID
    cyc(1, 32'h71, 0, 0, 0, 0);
    cyc(1, 32'h72, 0, 0, 0, 0);
    in_valid = 0;
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", {31'b0, out_valid}, 32'h0);
    chk("areset_rdy", {31'b0, in_ready}, 32'h1);
    chk("areset_data", out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef PIPE_FRAME_STALL_CNT_EN
    cyc(1, 32'h81, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("stall_saturated", {28'b0, stall_count}, 32'hF);
    cyc(0, 0, 0, 1, 0, 0);
    chk("stall_after_flush", {28'b0, stall_count}, 32'hF);
`else
    cyc(1, 32'h81, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("long_hold", out_data, 32'h81);
    cyc(0, 0, 0, 1, 0, 0);
`endif
    cyc(0, 0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_frame_skid.md
Name: pipe_frame_skid

Overview:
- Parametrised successor to the fixed-field pipeline instruction frame.
- Registers a pipeline frame of NUM_FIELDS equal-width fields between two stages using a valid/ready handshake.
- Uses a 2-entry skid buffer, so upstream ready is fully registered and throughput is one frame per cycle.
- Supports a synchronous flush (bubble/kill) and per-field in-place patching of the held head frame while stalled, e.g. for late operand forwarding.

Parameters:
- FIELD_WIDTH, 32, width of one frame field in bits.
- NUM_FIELDS, 8, number of fields in a frame; frame width FRAME_W = NUM_FIELDS*FIELD_WIDTH.
- STALL_CNT_WIDTH, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held frames.
- in_valid  in  1  upstream frame valid.
- in_ready  out  1  upstream may transfer; registered.
- in_data  in  FRAME_W  upstream frame; field k occupies bits [k*FIELD_WIDTH +: FIELD_WIDTH].
- patch_we  in  NUM_FIELDS  per-field patch enable for the head frame.
- patch_data  in  FRAME_W  patch values, same field layout as in_data.
- out_valid  out  1  head frame valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  FRAME_W  head frame; registered.
- stall_count  out  STALL_CNT_WIDTH  saturating stall counter (only with PIPE_FRAME_STALL_CNT_EN).

Behaviour:
- Reset (async assert): state EMPTY, head and skid data = 0, out_valid = 0, in_ready = 1, stall_count = 0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- State encoding: EMPTY (0 entries), FULL (head only), SKID (head + skid).
- EMPTY: push -> FULL, head <= in_data.
- FULL:
  - push & pop -> FULL, head <= in_data.
  - push & !pop -> SKID, skid <= in_data.
  - !push & pop -> EMPTY.
  - neither -> FULL.
- SKID: in_ready = 0, so no push. pop -> FULL, head <= skid. No pop -> hold.
- in_ready is a registered copy of (next_state != SKID). out_valid = (state != EMPTY).
- Latency: a frame accepted at edge N appears on out_data after edge N (1 cycle) when the buffer was EMPTY, or when FULL with a simultaneous pop.
- Ordering: strict FIFO; no frame is duplicated or dropped except by flush.
- Patch:
  - Applies only when out_valid & !pop. For each k with patch_we[k]=1, head field k <= patch field k. Fields with patch_we[k]=0 are untouched.
  - Never modifies the skid entry.
  - Ignored when EMPTY or when the head pops that cycle.
- Flush:
  - Highest priority below reset. Next state is EMPTY; head and skid are zeroed; out_valid = 0 next cycle; in_ready = 1 next cycle.
  - A push coinciding with flush is consumed and discarded.
  - A pop coinciding with flush still counts as delivered downstream.
  - Patch is ignored during flush.
- Reset mid-operation: immediate return to the reset values, with no partial-frame output.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: PIPE_FRAME_STALL_CNT_EN.
- Defined: stall_count increments each cycle in which out_valid & !out_ready & !flush.
  - Saturates at 2^STALL_CNT_WIDTH-1.
  - Cleared only by reset.
  - Port present.
- Undefined: the stall_count port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_frame_pkg:
  - State encoding constants PF_EMPTY=2'd0, PF_FULL=2'd1, PF_SKID=2'd2.
  - Field-slice helper function/macro field(k).
  - Default FIELD_WIDTH tied to `DATA_WIDTH from the global header.
- One sub-module, pipe_frame_patch_merge: combinational per-field mux producing the patched head from head, patch_data and patch_we.
- The top level holds the FSM, the two entry registers and the optional counter.

Test Plan:
- Reset then stream: out_ready=1, in_valid=1 with frames 0x1,0x2,0x3 in field 0 on consecutive cycles -> out_data field 0 = 0x1,0x2,0x3 one cycle later each, in_ready stays 1.
- Backpressure: out_ready=0 while pushing 0xA,0xB -> state SKID, in_ready=0 after the second edge; 0xC held off. Release out_ready -> outputs 0xA,0xB,0xC in order with no loss.
- Patch: head holds fields {f0=0x10,f1=0x20}, out_ready=0, patch_we=2'b10, patch f1=0x99 -> next cycle head {0x10,0x99}; the skid entry is unchanged after it is promoted.
- Flush while SKID with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=0; the flushed-cycle input never appears.
- Async reset asserted mid-cycle during SKID -> out_valid=0 and in_ready=1 without waiting for a clock edge.
- With PIPE_FRAME_STALL_CNT_EN and STALL_CNT_WIDTH=4: 20 stalled cycles -> stall_count=15 (saturated); a flush does not clear it.
